// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue in a FIFO,
// and a pending-write scoreboard exposes RAW hazards on outstanding secondary destinations.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          p_valid,
  input  logic [ADDR_W-1:0]             p_reg,
  input  logic [DATA_W-1:0]             p_data,
  output logic                          p_stall,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [ADDR_W-1:0]             s_reg,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_reg,
  input  logic [ADDR_W-1:0]             chk_rs,
  input  logic [ADDR_W-1:0]             chk_rt,
  output logic                          hazard,
  output logic                          regWen,
  output logic [ADDR_W-1:0]             writeReg,
  output logic [DATA_W-1:0]             writeData,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  logic [ADDR_W-1:0] fifo_reg_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              push, pop;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign s_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign push      = s_valid & s_ready;
  assign pop       = ~p_valid & (count_q != '0);
  assign head_reg  = fifo_reg_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (p_valid) begin
      wen_d   = (p_reg != '0);
      wreg_d  = p_reg;
      wdata_d = p_data;
    end else if (pop) begin
      wen_d   = (head_reg != '0);
      wreg_d  = head_reg;
      wdata_d = head_data;
    end
  end

  // Starvation counter saturates at the limit; the stall flag drops on the next pop.
  always_comb begin
    starve_d = starve_q;
    if (pop || count_q == '0)
      starve_d = '0;
    else if (p_valid && starve_q != SC_W'(STARVE_LIM))
      starve_d = starve_q + SC_W'(1);
    stall_d = pop ? 1'b0 : (stall_q | (starve_d == SC_W'(STARVE_LIM)));
  end

  // Clear before set so a same-cycle issue to a just-popped register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (pop)       pend_d[head_reg] = 1'b0;
    if (iss_valid) pend_d[iss_reg]  = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
      wen_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
      wen_q    <= wen_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= s_reg;
      fifo_data_q[wr_ptr_q] <= s_data;
    end
  end

  assign hazard     = pend_q[chk_rs] | pend_q[chk_rt];
  assign p_stall    = stall_q;
  assign regWen     = wen_q;
  assign writeReg   = wreg_q;
  assign writeData  = wdata_q;
  assign fifo_count = count_q;

endmodule
